// File: rtl/elastic_pipeline_pkg.sv
// Shared types and sizing helpers for the elastic valid/ready pipeline.
package elastic_pipeline_pkg;

  localparam int c_max_stages = 64;

  typedef struct packed {
    logic main_valid;
    logic skid_valid;
  } stage_state_t;

  function automatic int occupancy_width(input int p_stages);
    return $clog2(2 * p_stages + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One registered skid stage: main register feeds downstream, skid catches the beat in flight on a stall.
// Latency: 1 cycle. Backpressure: o_ready is the registered !skid_valid, so i_ready never reaches o_ready.
module elastic_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int p_width = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_width-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_width-1:0] o_data
);

  stage_state_t       state_q, state_d;
  logic [p_width-1:0] main_q, main_d;
  logic [p_width-1:0] skid_q, skid_d;
  logic               in_fire;
  logic               out_fire;

  // Reset gates ready combinationally so the stage refuses beats while held in reset.
  assign o_ready  = !state_q.skid_valid && !i_rst;
  assign o_valid  = state_q.main_valid;
  assign o_data   = main_q;
  assign in_fire  = i_valid && o_ready;
  assign out_fire = state_q.main_valid && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (out_fire || !state_q.main_valid) begin
      if (state_q.skid_valid) begin
        main_d             = skid_q;
        state_d.main_valid = 1'b1;
        state_d.skid_valid = 1'b0;
      end else begin
        main_d             = in_fire ? i_data : main_q;
        state_d.main_valid = in_fire;
      end
    end else if (in_fire) begin
      skid_d             = i_data;
      state_d.skid_valid = 1'b1;
    end
    // Flush only drops the valid flags; stale data is harmless once invalid.
    if (i_flush) begin
      state_d = '0;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= '0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Chain of p_stages skid stages; ELASTIC_PIPELINE_OCCUPANCY_EN adds the o_occupancy counter.
// Latency: p_stages cycles. Backpressure: holds up to 2*p_stages beats, never drops, no i_ready->o_ready path.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int p_width  = 32,
  parameter int p_stages = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [p_width-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_width-1:0] o_data
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  ,
  output logic [occupancy_width(p_stages)-1:0] o_occupancy
`endif
);

  logic               vld_chain [p_stages+1];
  logic               rdy_chain [p_stages+1];
  logic [p_width-1:0] dat_chain [p_stages+1];

  assign vld_chain[0]        = i_valid;
  assign dat_chain[0]        = i_data;
  assign o_ready             = rdy_chain[0];
  assign rdy_chain[p_stages] = i_ready;
  assign o_valid             = vld_chain[p_stages];
  assign o_data              = dat_chain[p_stages];

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    elastic_stage #(
      .p_width(p_width)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_flush(i_flush),
      .i_valid(vld_chain[k]),
      .o_ready(rdy_chain[k]),
      .i_data (dat_chain[k]),
      .o_valid(vld_chain[k+1]),
      .i_ready(rdy_chain[k+1]),
      .o_data (dat_chain[k+1])
    );
  end

  a_stages_legal : assert property (@(posedge i_clk) (p_stages >= 1) && (p_stages <= c_max_stages));

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  localparam int c_occ_w = occupancy_width(p_stages);

  logic [c_occ_w-1:0] occ_q;
  logic               occ_in;
  logic               occ_out;

  assign occ_in      = i_valid && o_ready;
  assign occ_out     = o_valid && i_ready;
  assign o_occupancy = occ_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      occ_q <= '0;
    end else if (occ_in && !occ_out) begin
      occ_q <= occ_q + c_occ_w'(1);
    end else if (!occ_in && occ_out) begin
      occ_q <= occ_q - c_occ_w'(1);
    end
  end

  a_occ_bound : assert property (@(posedge i_clk) disable iff (i_rst) occ_q <= c_occ_w'(2 * p_stages));
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline: an 8-stage instance for the main scenarios and a 1-stage corner instance.
module tb_elastic_pipeline;
  import elastic_pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        a_flush, a_vld, a_rdy, a_ordy, a_ovld;
  logic [31:0] a_dat, a_odat;
  logic        b_flush, b_vld, b_rdy, b_ordy, b_ovld;
  logic [31:0] b_dat, b_odat;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  logic [occupancy_width(8)-1:0] a_occ;
  logic [occupancy_width(1)-1:0] b_occ;
`endif

  int checks = 0;
  int passes = 0;

  elastic_pipeline #(.p_width(32), .p_stages(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(a_flush), .i_valid(a_vld), .o_ready(a_ordy),
    .i_data(a_dat), .o_valid(a_ovld), .i_ready(a_rdy), .o_data(a_odat)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    , .o_occupancy(a_occ)
`endif
  );

  elastic_pipeline #(.p_width(32), .p_stages(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(b_flush), .i_valid(b_vld), .o_ready(b_ordy),
    .i_data(b_dat), .o_valid(b_ovld), .i_ready(b_rdy), .o_data(b_odat)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    , .o_occupancy(b_occ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_ovld !== 1'b0) $display("FAIL reset_o_valid: got %0b want 0", a_ovld); else passes++;
    checks++; if (a_odat !== 32'h0) $display("FAIL reset_o_data: got %h want 0", a_odat); else passes++;
    checks++; if (a_ordy !== 1'b0) $display("FAIL reset_o_ready_held: got %0b want 0", a_ordy); else passes++;
    checks++; if (b_ordy !== 1'b0) $display("FAIL reset_o_ready_held_1stage: got %0b want 0", b_ordy); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (a_ordy !== 1'b1) $display("FAIL reset_o_ready_release: got %0b want 1", a_ordy); else passes++;
    checks++; if (b_ordy !== 1'b1) $display("FAIL reset_o_ready_release_1stage: got %0b want 1", b_ordy); else passes++;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    checks++; if (a_occ !== '0) $display("FAIL reset_occupancy: got %0d want 0", a_occ); else passes++;
`endif
  endtask

  task automatic test_streaming();
    int sent = 0, got = 0, edges = 0, first_out = -1, gaps = 0;
    bit ready_dropped = 0, fire;
    @(negedge clk);
    a_rdy = 1'b1; a_vld = 1'b1; a_dat = 32'd0;
    while (got < 100 && edges < 300) begin
      fire = a_vld && a_ordy;
      if (a_vld && !a_ordy) ready_dropped = 1;
      @(negedge clk);
      edges++;
      if (fire) begin
        sent++;
        a_dat = 32'(sent);
        if (sent == 100) a_vld = 1'b0;
      end
      if (a_ovld) begin
        if (first_out < 0) first_out = edges;
        checks++;
        if (a_odat !== 32'(got)) $display("FAIL stream_data: got %0d want %0d", a_odat, got); else passes++;
        got++;
      end else if (first_out >= 0) gaps++;
    end
    checks++; if (got != 100) $display("FAIL stream_count: got %0d want 100", got); else passes++;
    checks++; if (first_out != 8) $display("FAIL stream_latency: got %0d want 8", first_out); else passes++;
    checks++; if (gaps != 0) $display("FAIL stream_gaps: got %0d want 0", gaps); else passes++;
    checks++; if (ready_dropped) $display("FAIL stream_o_ready: got dropped want always 1"); else passes++;
    @(negedge clk);
    checks++; if (a_ovld !== 1'b0) $display("FAIL stream_tail_empty: got %0b want 0", a_ovld); else passes++;
  endtask

  task automatic test_fill();
    int acc = 0, got = 0, gaps = 0, edges = 0;
    bit fire;
    @(negedge clk);
    a_rdy = 1'b0; a_vld = 1'b1; a_dat = 32'hA0;
    repeat (30) begin
      fire = a_vld && a_ordy;
      @(negedge clk);
      if (fire) begin
        acc++;
        a_dat = 32'hA0 + 32'(acc);
      end
    end
    checks++; if (acc != 16) $display("FAIL fill_accepted: got %0d want 16", acc); else passes++;
    checks++; if (a_ordy !== 1'b0) $display("FAIL fill_o_ready: got %0b want 0", a_ordy); else passes++;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    checks++; if (a_occ !== 5'd16) $display("FAIL fill_occupancy_full: got %0d want 16", a_occ); else passes++;
`endif
    a_vld = 1'b0; a_rdy = 1'b1;
    while (got < 16 && edges < 40) begin
      if (a_ovld) begin
        checks++;
        if (a_odat !== 32'hA0 + 32'(got)) $display("FAIL fill_drain_data: got %h want %h", a_odat, 32'hA0 + 32'(got));
        else passes++;
        got++;
      end else gaps++;
      @(negedge clk);
      edges++;
    end
    checks++; if (got != 16) $display("FAIL fill_drain_count: got %0d want 16", got); else passes++;
    checks++; if (gaps != 0) $display("FAIL fill_drain_gaps: got %0d want 0", gaps); else passes++;
    checks++; if (a_ovld !== 1'b0) $display("FAIL fill_drain_empty: got %0b want 0", a_ovld); else passes++;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    checks++; if (a_occ !== '0) $display("FAIL fill_occupancy_empty: got %0d want 0", a_occ); else passes++;
`endif
  endtask

  task automatic test_random_stall();
    logic [31:0] q[$];
    logic [31:0] exp_dat, hold_dat;
    int sent = 0, got = 0, edges = 0;
    bit hold = 0, in_fire, out_fire;
    hold_dat = '0;
    @(negedge clk);
    while (got < 1000 && edges < 20000) begin
      if (hold) begin
        checks++;
        if (a_ovld !== 1'b1 || a_odat !== hold_dat)
          $display("FAIL random_hold: got vld=%0b dat=%h want vld=1 dat=%h", a_ovld, a_odat, hold_dat);
        else passes++;
      end
      a_vld = (sent < 1000) && ($urandom_range(0, 1) == 1);
      a_dat = $urandom;
      a_rdy = ($urandom_range(0, 1) == 1);
      in_fire  = a_vld && a_ordy;
      out_fire = a_ovld && a_rdy;
      if (out_fire) begin
        checks++;
        if (q.size() == 0) $display("FAIL random_extra: got %h want no beat", a_odat);
        else begin
          exp_dat = q.pop_front();
          if (a_odat !== exp_dat) $display("FAIL random_order: got %h want %h", a_odat, exp_dat); else passes++;
        end
        got++;
      end
      if (in_fire) begin
        q.push_back(a_dat);
        sent++;
      end
      hold = a_ovld && !a_rdy;
      hold_dat = a_odat;
      @(negedge clk);
      edges++;
    end
    a_vld = 1'b0; a_rdy = 1'b1;
    checks++; if (got != 1000) $display("FAIL random_count: got %0d want 1000", got); else passes++;
    checks++; if (q.size() != 0) $display("FAIL random_leftover: got %0d want 0", q.size()); else passes++;
    @(negedge clk);
    checks++; if (a_ovld !== 1'b0) $display("FAIL random_tail_empty: got %0b want 0", a_ovld); else passes++;
  endtask

  task automatic test_flush();
    int edges = 0, extra = 0;
    @(negedge clk);
    a_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_vld = 1'b1; a_dat = 32'h100 + 32'(i);
      @(negedge clk);
    end
    a_vld = 1'b1; a_dat = 32'hDEAD; a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0; a_vld = 1'b0;
    checks++; if (a_ovld !== 1'b0) $display("FAIL flush_o_valid: got %0b want 0", a_ovld); else passes++;
    checks++; if (a_ordy !== 1'b1) $display("FAIL flush_o_ready: got %0b want 1", a_ordy); else passes++;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    checks++; if (a_occ !== '0) $display("FAIL flush_occupancy: got %0d want 0", a_occ); else passes++;
`endif
    a_vld = 1'b1; a_dat = 32'h1;
    @(negedge clk);
    edges = 1;
    a_vld = 1'b0;
    while (!a_ovld && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checks++; if (edges != 8) $display("FAIL flush_next_latency: got %0d want 8", edges); else passes++;
    checks++; if (a_odat !== 32'h1) $display("FAIL flush_next_data: got %h want 00000001", a_odat); else passes++;
    @(negedge clk);
    repeat (15) begin
      if (a_ovld) extra++;
      @(negedge clk);
    end
    checks++; if (extra != 0) $display("FAIL flush_leftover: got %0d beats want 0", extra); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_rdy = 1'b0; a_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_dat = 32'h55 + 32'(i);
      @(negedge clk);
    end
    a_vld = 1'b0;
    checks++; if (a_ovld !== 1'b1 || a_odat !== 32'h55)
      $display("FAIL rstmid_full_head: got vld=%0b dat=%h want vld=1 dat=00000055", a_ovld, a_odat); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (a_ordy !== 1'b0) $display("FAIL rstmid_o_ready_assert: got %0b want 0", a_ordy); else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_ovld !== 1'b0) $display("FAIL rstmid_o_valid: got %0b want 0", a_ovld); else passes++;
    checks++; if (a_odat !== 32'h0) $display("FAIL rstmid_o_data: got %h want 0", a_odat); else passes++;
    checks++; if (a_ordy !== 1'b0) $display("FAIL rstmid_o_ready_held: got %0b want 0", a_ordy); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (a_ordy !== 1'b1) $display("FAIL rstmid_o_ready_release: got %0b want 1", a_ordy); else passes++;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    checks++; if (a_occ !== '0) $display("FAIL rstmid_occupancy: got %0d want 0", a_occ); else passes++;
`endif
    a_rdy = 1'b1;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (a_ovld) seen++;
      end
      checks++; if (seen != 0) $display("FAIL rstmid_discard: got %0d beats want 0", seen); else passes++;
    end
  endtask

  task automatic test_single_stage();
    @(negedge clk);
    b_rdy = 1'b0; b_vld = 1'b1; b_dat = 32'h5;
    checks++; if (b_ordy !== 1'b1) $display("FAIL single_accept_first: got %0b want 1", b_ordy); else passes++;
    @(negedge clk);
    b_dat = 32'h6;
    checks++; if (b_ordy !== 1'b1) $display("FAIL single_accept_second: got %0b want 1", b_ordy); else passes++;
    @(negedge clk);
    b_dat = 32'h7;
    checks++; if (b_ordy !== 1'b0) $display("FAIL single_refuse_third: got %0b want 0", b_ordy); else passes++;
    checks++; if (b_ovld !== 1'b1 || b_odat !== 32'h5)
      $display("FAIL single_head: got vld=%0b dat=%h want vld=1 dat=00000005", b_ovld, b_odat); else passes++;
    @(negedge clk);
    b_vld = 1'b0;
    checks++; if (b_ordy !== 1'b0 || b_odat !== 32'h5)
      $display("FAIL single_stalled: got rdy=%0b dat=%h want rdy=0 dat=00000005", b_ordy, b_odat); else passes++;
    b_rdy = 1'b1;
    @(negedge clk);
    checks++; if (b_ovld !== 1'b1 || b_odat !== 32'h6)
      $display("FAIL single_second_out: got vld=%0b dat=%h want vld=1 dat=00000006", b_ovld, b_odat); else passes++;
    @(negedge clk);
    checks++; if (b_ovld !== 1'b0) $display("FAIL single_empty: got %0b want 0", b_ovld); else passes++;
    @(negedge clk);
    checks++; if (b_ovld !== 1'b0) $display("FAIL single_no_third: got %0b want 0", b_ovld); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_vld = 1'b0; a_rdy = 1'b0; a_dat = '0;
    b_flush = 1'b0; b_vld = 1'b0; b_rdy = 1'b0; b_dat = '0;
    test_reset();
    test_streaming();
    test_fill();
    test_random_stall();
    test_flush();
    test_reset_mid();
    test_single_stage();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
Name: elastic_pipeline

Overview:
- Multi-stage data pipeline with valid/ready flow control. The ready (backpressure) path travels in the opposite direction to the data.
- Sits between a producer and a consumer that may stall. Unlike the free-running register pipeline, a stall holds data in place and never drops it.
- Each stage is a registered skid stage, so no combinational path runs from o_ready... specifically, no combinational path from i_ready to o_ready.

Parameters:
- p_width, 32, data width in bits
- p_stages, 8, number of skid stages; legal range 1..64

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_flush  input  1  synchronous discard of all in-flight data
- i_valid  input  1  producer has data on i_data
- o_ready  output  1  pipeline accepts i_data this cycle
- i_data  input  p_width  producer data
- o_valid  output  1  o_data holds valid data
- i_ready  input  1  consumer accepts o_data this cycle
- o_data  output  p_width  consumer data
- o_occupancy  output  $clog2(2*p_stages+1)  entries held; present only with the optional feature

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high.
- Handshakes:
  - Input transfer: i_valid && o_ready on a rising edge.
  - Output transfer: o_valid && i_ready on a rising edge.
  - Once o_valid is asserted, o_data holds stable until the output transfer completes.
- Stage structure: each stage has a main register and a skid register, each with its own valid flag.
  - Stage ready-out = !skid_valid, registered. Stage k's ready-out drives stage k-1's ready-in. The last stage's ready-in is i_ready.
  - Stage outputs the main register.
  - If main is occupied and downstream is not ready, an incoming transfer lands in skid.
  - When downstream accepts: skid moves to main (if skid valid); otherwise the incoming beat moves to main; otherwise main goes empty.
- Latency: p_stages cycles from input transfer to o_valid when the pipeline is empty and unstalled.
- Throughput: one beat per cycle sustained while i_ready=1.
- Capacity: 2*p_stages beats. With i_ready held low, o_ready deasserts after exactly 2*p_stages accepted beats.
- Ordering: strict FIFO order. No beat is dropped or duplicated except by flush or reset.
- Reset (i_rst=1):
  - All valid flags clear; o_valid=0; o_data=0; all data registers=0.
  - o_ready=0 while i_rst=1, and 1 in the first cycle after i_rst falls.
  - Reset mid-stream discards all in-flight data.
  - i_rst takes priority over i_flush.
- Flush (i_flush=1):
  - Clears every valid flag at the edge. Data registers are left unchanged.
  - An input transfer on the flush cycle is discarded.
  - An output transfer on the flush cycle completes: the consumer saw it.
  - o_ready=1 the cycle after the flush.
- Simultaneous input and output transfer on a full pipeline: impossible, since o_ready=0 when full.
- Simultaneous input and output transfer on a partially full pipeline: occupancy unchanged.
- i_valid may drop without a transfer; the pipeline does not require valid to be held.

Optional Feature:
- Macro: ELASTIC_PIPELINE_OCCUPANCY_EN
- Defined:
  - o_occupancy port exists. It is a registered count of valid entries, reset to 0.
  - Increments on input transfer, decrements on output transfer, is unchanged when both happen, and goes to 0 on flush.
  - An assertion checks o_occupancy <= 2*p_stages.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Decomposition:
- Package elastic_pipeline_pkg:
  - constant c_max_stages = 64
  - typedef stage_state_t: main_valid, skid_valid
  - function occupancy_width(p_stages) returns $clog2(2*p_stages+1)
- Sub-module elastic_stage:
  - One skid stage with ports i_clk, i_rst, i_flush, i_valid/o_ready/i_data upstream and o_valid/i_ready/o_data downstream.
  - Instantiated p_stages times in a generate loop, chained by valid/data forward and ready backward arrays.

Test Plan:
- Streaming, p_stages=8: reset, then 100 beats 0..99 with i_ready=1 and i_valid=1 -> first o_valid 8 cycles after first accept; outputs 0..99 in order, one per cycle, o_ready never low.
- Fill: i_ready=0 with i_valid=1 and data 0xA0.. -> exactly 16 beats accepted, then o_ready=0. Raise i_ready -> 0xA0..0xAF drain in order, one per cycle; occupancy (feature on) goes 16->0.
- Random stall: i_valid and i_ready each 50% random, 1000 beats -> scoreboard matches, no loss or duplication; o_data stable while o_valid && !i_ready.
- Flush mid-stream: 5 beats in flight, pulse i_flush together with an input beat 0xDEAD -> o_valid=0 next cycle, 0xDEAD never emerges, o_ready=1; next beat 0x1 emerges after 8 cycles.
- Reset mid-operation: pipeline full, assert i_rst 2 cycles -> o_valid=0, o_data=0, o_ready=0 during reset, 1 the cycle after; occupancy=0.
- p_stages=1 corner: capacity 2. Beats 0x5,0x6 accepted with i_ready=0, third refused; i_ready=1 -> 0x5 then 0x6.
